// File: rtl/instr_encoder_if.sv
// instr_encoder_if: request/response bundle of the MIPS instruction encoder.
//   Request side : in_valid/in_ready handshake, in_op selector, register,
//                  shift, immediate and jump-target fields.
//   Output side  : out_valid/out_ready handshake, out_word/out_addr head of
//                  queue, emitted word count, sticky err/err_op status.
// The encoder itself uses the slave modport. A producer/consumer (loader,
// self-test block or bench) uses the master modport.
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_op;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [4:0]  in_shamt;
    logic [15:0] in_imm;
    logic [25:0] in_addr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [31:0] out_addr;
    logic [15:0] emitted;
    logic        err;
    logic [5:0]  err_op;

    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_addr,
        input  out_ready,
        output in_ready, out_valid, out_word, out_addr, emitted, err, err_op
    );

    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_addr,
        output out_ready,
        input  in_ready, out_valid, out_word, out_addr, emitted, err, err_op
    );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs mnemonic-level requests into canonical MIPS32 words,
// queues them in a DEPTH-entry FIFO and emits each word with its
// instruction-memory address.
// Ports:
//   clk   - system clock, all state on rising edge
//   reset - asynchronous active-high reset, clears all state
//   clear - synchronous flush (FIFO, address, count and error status)
//   bus   - instr_encoder_if.slave request/output bundle
module instr_encoder #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    instr_encoder_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {FMT_R = 2'd0, FMT_I = 2'd1, FMT_J = 2'd2} fmt_e;

    fmt_e        fmt_s;
    logic [5:0]  opcode_s;
    logic [5:0]  funct_s;
    logic [4:0]  rs_s;
    logic [4:0]  rt_s;
    logic [4:0]  rd_s;
    logic [4:0]  shamt_s;
    logic        legal_s;
    logic [31:0] word_s;

    logic [31:0] mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0] level_q, level_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] emitted_q, emitted_d;
    logic        err_q, err_d;
    logic [5:0]  err_op_q, err_op_d;

    logic accept_s, push_s, pop_s, valid_s;

    // Operation decode: selects format, opcode/funct and forces unused fields to zero.
    always_comb begin
        fmt_s    = FMT_R;
        opcode_s = 6'h00;
        funct_s  = 6'h00;
        rs_s     = bus.in_rs;
        rt_s     = bus.in_rt;
        rd_s     = bus.in_rd;
        shamt_s  = 5'd0;
        legal_s  = 1'b1;
        case (bus.in_op)
            6'd0:  funct_s = 6'h20;
            6'd1:  funct_s = 6'h21;
            6'd2:  funct_s = 6'h22;
            6'd3:  funct_s = 6'h23;
            6'd4:  funct_s = 6'h24;
            6'd5:  funct_s = 6'h25;
            6'd6:  funct_s = 6'h26;
            6'd7:  funct_s = 6'h27;
            6'd8:  funct_s = 6'h2a;
            6'd9:  funct_s = 6'h2b;
            6'd10: begin funct_s = 6'h00; rs_s = 5'd0; shamt_s = bus.in_shamt; end
            6'd11: begin funct_s = 6'h02; rs_s = 5'd0; shamt_s = bus.in_shamt; end
            6'd12: begin funct_s = 6'h03; rs_s = 5'd0; shamt_s = bus.in_shamt; end
            6'd13: funct_s = 6'h04;
            6'd14: funct_s = 6'h06;
            6'd15: funct_s = 6'h07;
            6'd16: begin funct_s = 6'h18; rd_s = 5'd0; end
            6'd17: begin funct_s = 6'h19; rd_s = 5'd0; end
            6'd18: begin funct_s = 6'h1a; rd_s = 5'd0; end
            6'd19: begin funct_s = 6'h1b; rd_s = 5'd0; end
            6'd20: begin funct_s = 6'h08; rt_s = 5'd0; rd_s = 5'd0; end
            6'd21: begin funct_s = 6'h09; rt_s = 5'd0; end
            6'd22: begin fmt_s = FMT_I; opcode_s = 6'h08; end
            6'd23: begin fmt_s = FMT_I; opcode_s = 6'h09; end
            6'd24: begin fmt_s = FMT_I; opcode_s = 6'h0c; end
            6'd25: begin fmt_s = FMT_I; opcode_s = 6'h0d; end
            6'd26: begin fmt_s = FMT_I; opcode_s = 6'h0e; end
            6'd27: begin fmt_s = FMT_I; opcode_s = 6'h0f; rs_s = 5'd0; end
            6'd28: begin fmt_s = FMT_I; opcode_s = 6'h0a; end
            6'd29: begin fmt_s = FMT_I; opcode_s = 6'h0b; end
            6'd30: begin fmt_s = FMT_I; opcode_s = 6'h23; end
            6'd31: begin fmt_s = FMT_I; opcode_s = 6'h21; end
            6'd32: begin fmt_s = FMT_I; opcode_s = 6'h25; end
            6'd33: begin fmt_s = FMT_I; opcode_s = 6'h20; end
            6'd34: begin fmt_s = FMT_I; opcode_s = 6'h24; end
            6'd35: begin fmt_s = FMT_I; opcode_s = 6'h2b; end
            6'd36: begin fmt_s = FMT_I; opcode_s = 6'h29; end
            6'd37: begin fmt_s = FMT_I; opcode_s = 6'h28; end
            6'd38: begin fmt_s = FMT_I; opcode_s = 6'h04; end
            6'd39: begin fmt_s = FMT_I; opcode_s = 6'h05; end
            6'd40: begin fmt_s = FMT_I; opcode_s = 6'h06; rt_s = 5'd0; end
            6'd41: begin fmt_s = FMT_I; opcode_s = 6'h07; rt_s = 5'd0; end
            // REGIMM: the rt field selects bltz (0) or bgez (1)
            6'd42: begin fmt_s = FMT_I; opcode_s = 6'h01; rt_s = 5'd0; end
            6'd43: begin fmt_s = FMT_I; opcode_s = 6'h01; rt_s = 5'd1; end
            6'd44: begin fmt_s = FMT_J; opcode_s = 6'h02; end
            6'd45: begin fmt_s = FMT_J; opcode_s = 6'h03; end
            default: legal_s = 1'b0;
        endcase
    end

    // Word assembly from the decoded fields.
    always_comb begin
        case (fmt_s)
            FMT_R:   word_s = {6'h00, rs_s, rt_s, rd_s, shamt_s, funct_s};
            FMT_I:   word_s = {opcode_s, rs_s, rt_s, bus.in_imm};
            FMT_J:   word_s = {opcode_s, bus.in_addr};
            default: word_s = 32'd0;
        endcase
    end

    assign valid_s  = (level_q != {LW{1'b0}});
    assign accept_s = bus.in_valid & bus.in_ready;
    // A flush swallows any concurrent accept or pop.
    assign push_s   = accept_s & legal_s & ~clear;
    assign pop_s    = valid_s & bus.out_ready & ~clear;

    // Next-state: pointers, level, address, count and sticky error status.
    always_comb begin
        wr_d      = wr_q;
        rd_d      = rd_q;
        level_d   = level_q;
        addr_d    = addr_q;
        emitted_d = emitted_q;
        err_d     = err_q;
        err_op_d  = err_op_q;
        if (clear) begin
            wr_d      = {PW{1'b0}};
            rd_d      = {PW{1'b0}};
            level_d   = {LW{1'b0}};
            addr_d    = BASE_ADDR;
            emitted_d = 16'd0;
            err_d     = 1'b0;
            err_op_d  = 6'd0;
        end else begin
            wr_d      = push_s ? wr_q + PW'(1) : wr_q;
            rd_d      = pop_s ? rd_q + PW'(1) : rd_q;
            addr_d    = pop_s ? addr_q + 32'd4 : addr_q;
            emitted_d = pop_s ? emitted_q + 16'd1 : emitted_q;
            case ({push_s, pop_s})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
            if (accept_s && !legal_s) begin
                err_d    = 1'b1;
                // Only the first illegal op is remembered.
                err_op_d = err_q ? err_op_q : bus.in_op;
            end else begin
                err_d    = err_q;
                err_op_d = err_op_q;
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q      <= {PW{1'b0}};
            rd_q      <= {PW{1'b0}};
            level_q   <= {LW{1'b0}};
            addr_q    <= BASE_ADDR;
            emitted_q <= 16'd0;
            err_q     <= 1'b0;
            err_op_q  <= 6'd0;
        end else begin
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            level_q   <= level_d;
            addr_q    <= addr_d;
            emitted_q <= emitted_d;
            err_q     <= err_d;
            err_op_q  <= err_op_d;
        end
    end

    // FIFO storage; contents are only observed while the level marks them valid.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_q] <= word_s;
        end
    end

    assign bus.in_ready  = (level_q < LW'(DEPTH));
    assign bus.out_valid = valid_s;
    assign bus.out_word  = valid_s ? mem_q[rd_q] : 32'd0;
    assign bus.out_addr  = addr_q;
    assign bus.emitted   = emitted_q;
    assign bus.err       = err_q;
    assign bus.err_op    = err_op_q;
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed test of instr_encoder (DEPTH=4, BASE 0x3000).
module tb_instr_encoder;
    logic clk;
    logic reset;
    logic clear;
    int   tests;
    int   fails;
    logic [31:0] sb [$];
    logic [31:0] exp_w [5];
    logic        acc;

    instr_encoder_if bus ();

    instr_encoder #(.DEPTH(4), .BASE_ADDR(32'h0000_3000)) dut (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present one request and hold it until accepted (bounded wait).
    task automatic send(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh,
                        input logic [15:0] imm, input logic [25:0] ja);
        int cnt;
        bus.in_op = op; bus.in_rs = rs; bus.in_rt = rt; bus.in_rd = rd;
        bus.in_shamt = sh; bus.in_imm = imm; bus.in_addr = ja;
        bus.in_valid = 1'b1;
        cnt = 0;
        while (!bus.in_ready && cnt < 50) begin
            @(posedge clk); #1;
            cnt++;
        end
        tests++;
        assert (cnt < 50) else begin
            fails++;
            $error("FAIL send_timeout: observed %0d cycles, expected < 50", cnt);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        tests = 0; fails = 0;
        reset = 1'b1; clear = 1'b0;
        bus.in_valid = 1'b0; bus.in_op = 6'd0; bus.in_rs = 5'd0; bus.in_rt = 5'd0;
        bus.in_rd = 5'd0; bus.in_shamt = 5'd0; bus.in_imm = 16'd0; bus.in_addr = 26'd0;
        bus.out_ready = 1'b0;
        #12;
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_word",  bus.out_word,       32'd0);
        chk("rst_out_addr",  bus.out_addr,       32'h0000_3000);
        chk("rst_emitted",   32'(bus.emitted),   32'd0);
        chk("rst_err",       32'(bus.err),       32'd0);
        chk("rst_err_op",    32'(bus.err_op),    32'd0);
        reset = 1'b0;
        tick();

        // Single-op encodings with the consumer always ready.
        bus.out_ready = 1'b1;
        send(6'd1, 5'd1, 5'd2, 5'd3, 5'd9, 16'hFFFF, 26'd0);
        chk("addu_word", bus.out_word, 32'h0022_1821);
        chk("addu_addr", bus.out_addr, 32'h0000_3000);
        send(6'd25, 5'd0, 5'd1, 5'd7, 5'd3, 16'h1234, 26'd0);
        chk("ori_word", bus.out_word, 32'h3401_1234);
        chk("ori_addr", bus.out_addr, 32'h0000_3004);
        send(6'd30, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'd0);
        chk("lw_word", bus.out_word, 32'h8FA8_0004);
        send(6'd43, 5'd4, 5'd9, 5'd0, 5'd0, 16'hFFFF, 26'd0);
        chk("bgez_word", bus.out_word, 32'h0481_FFFF);
        send(6'd45, 5'd3, 5'd3, 5'd3, 5'd3, 16'h0000, 26'h000_0C00);
        chk("jal_word", bus.out_word, 32'h0C00_0C00);
        chk("jal_addr", bus.out_addr, 32'h0000_3010);
        send(6'd10, 5'd7, 5'd1, 5'd2, 5'd4, 16'h0000, 26'd0);
        chk("sll_word", bus.out_word, 32'h0001_1100);
        send(6'd20, 5'd31, 5'd5, 5'd5, 5'd2, 16'h0000, 26'd0);
        chk("jr_word", bus.out_word, 32'h03E0_0008);
        tick();
        chk("series_empty",   32'(bus.out_valid), 32'd0);
        chk("series_emitted", 32'(bus.emitted),   32'd7);
        chk("series_addr",    bus.out_addr,       32'h0000_301C);

        clear = 1'b1; tick(); clear = 1'b0;
        chk("clr1_addr",    bus.out_addr,     32'h0000_3000);
        chk("clr1_emitted", 32'(bus.emitted), 32'd0);

        // Backpressure: four fill the queue, the fifth waits.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) exp_w[i] = 32'h2022_0000 | 32'(16'h10 + 16'(i));
        for (int i = 0; i < 4; i++) begin
            send(6'd22, 5'd1, 5'd2, 5'd31, 5'd0, 16'h10 + 16'(i), 26'd0);
            if (i == 2) chk("bp_ready_3", 32'(bus.in_ready), 32'd1);
        end
        chk("bp_ready_full", 32'(bus.in_ready), 32'd0);
        bus.in_op = 6'd22; bus.in_rs = 5'd1; bus.in_rt = 5'd2; bus.in_imm = 16'h14;
        bus.in_valid = 1'b1;
        tick(); tick();
        chk("bp_still_full", 32'(bus.in_ready), 32'd0);
        chk("bp_hold_word",  bus.out_word,      exp_w[0]);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_word",  bus.out_word,       exp_w[i]);
            chk("bp_addr",  bus.out_addr,       32'h0000_3000 + 32'(4 * i));
            acc = bus.in_valid & bus.in_ready;
            tick();
            if (acc) bus.in_valid = 1'b0;
        end
        chk("bp_in_valid_done", 32'(bus.in_valid), 32'd0);
        chk("bp_empty",   32'(bus.out_valid), 32'd0);
        chk("bp_emitted", 32'(bus.emitted),   32'd5);

        clear = 1'b1; tick(); clear = 1'b0;

        // Simultaneous push and pop at level 2.
        bus.out_ready = 1'b0;
        sb.delete();
        send(6'd24, 5'd3, 5'd4, 5'd0, 5'd0, 16'h00AA, 26'd0);
        sb.push_back(32'h3064_00AA);
        send(6'd24, 5'd3, 5'd4, 5'd0, 5'd0, 16'h00BB, 26'd0);
        sb.push_back(32'h3064_00BB);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.in_op = 6'd25; bus.in_rs = 5'd0; bus.in_rt = 5'd2;
            bus.in_imm = 16'(100 + k); bus.in_valid = 1'b1;
            chk("pp_ready", 32'(bus.in_ready), 32'd1);
            chk("pp_word",  bus.out_word,      sb[0]);
            tick();
            void'(sb.pop_front());
            sb.push_back(32'h3402_0000 | 32'(100 + k));
        end
        bus.in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("pp_tail_word", bus.out_word, sb[0]);
            tick();
            void'(sb.pop_front());
        end
        chk("pp_empty",   32'(bus.out_valid), 32'd0);
        chk("pp_emitted", 32'(bus.emitted),   32'd12);

        clear = 1'b1; tick(); clear = 1'b0;

        // Illegal op between two legal ones.
        bus.out_ready = 1'b0;
        send(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 26'd0);
        send(6'd50, 5'd1, 5'd1, 5'd1, 5'd1, 16'h0001, 26'd0);
        chk("ill_err",    32'(bus.err),    32'd1);
        chk("ill_err_op", 32'(bus.err_op), 32'd50);
        send(6'd2, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0000, 26'd0);
        send(6'd60, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0000, 26'd0);
        chk("ill_err_op_kept", 32'(bus.err_op), 32'd50);
        bus.out_ready = 1'b1;
        chk("ill_word0", bus.out_word, 32'h0022_1820);
        tick();
        chk("ill_word1", bus.out_word, 32'h0085_3022);
        tick();
        chk("ill_empty",   32'(bus.out_valid), 32'd0);
        chk("ill_emitted", 32'(bus.emitted),   32'd2);

        // Clear with three queued words and a concurrent legal push.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(6'd23, 5'd1, 5'd1, 5'd0, 5'd0, 16'(i), 26'd0);
        bus.in_op = 6'd23; bus.in_imm = 16'h0077; bus.in_valid = 1'b1;
        clear = 1'b1;
        tick();
        clear = 1'b0; bus.in_valid = 1'b0;
        chk("clr_valid",   32'(bus.out_valid), 32'd0);
        chk("clr_addr",    bus.out_addr,       32'h0000_3000);
        chk("clr_emitted", 32'(bus.emitted),   32'd0);
        chk("clr_err",     32'(bus.err),       32'd0);
        chk("clr_err_op",  32'(bus.err_op),    32'd0);
        tick();
        chk("clr_no_push", 32'(bus.out_valid), 32'd0);

        // Asynchronous reset mid-drain.
        for (int i = 0; i < 3; i++) send(6'd5, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 26'd0);
        bus.out_ready = 1'b1;
        tick();
        chk("ar_pre_emitted", 32'(bus.emitted), 32'd1);
        reset = 1'b1;
        #1;
        chk("ar_valid",    32'(bus.out_valid), 32'd0);
        chk("ar_word",     bus.out_word,       32'd0);
        chk("ar_addr",     bus.out_addr,       32'h0000_3000);
        chk("ar_emitted",  32'(bus.emitted),   32'd0);
        chk("ar_in_ready", 32'(bus.in_ready),  32'd1);
        chk("ar_err",      32'(bus.err),       32'd0);
        reset = 1'b0;
        tick();
        chk("ar_after_valid", 32'(bus.out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
